// File: rtl/param_updown_counter.sv
// param_updown_counter: modulo-(MAX_VAL+1) up/down counter with load, clear, wrap/saturate,
// Gray output, terminal-count pulse and sticky overflow/underflow flags.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter int SATURATE = 0
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam bit SAT = SATURATE != 0;
    logic [WIDTH-1:0] next_out;
    logic next_tc, next_ovf, next_udf;
    always_comb begin
        next_out = out;
        next_tc  = 1'b0;
        next_ovf = ovf & ~flag_clr;
        next_udf = udf & ~flag_clr;
        if (clear) begin
            next_out = '0;
            next_ovf = 1'b0;
            next_udf = 1'b0;
        end else if (load) begin
            next_out = (load_val > MAX) ? MAX : load_val;
        end else if (en && up_dn) begin
            next_out = (out == MAX) ? (SAT ? MAX : '0) : out + 1'b1;
            next_tc  = out == MAX;
            next_ovf = next_ovf | (out == MAX);
        end else if (en) begin
            next_out = (out == '0) ? (SAT ? '0 : MAX) : out - 1'b1;
            next_tc  = out == '0;
            next_udf = next_udf | (out == '0);
        end
    end
    always_ff @(posedge clk_out) begin
        if (!rst) begin
            out      <= '0;
            gray_out <= '0;
            tc       <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            out      <= next_out;
            gray_out <= next_out ^ (next_out >> 1);
            tc       <= next_tc;
            ovf      <= next_ovf;
            udf      <= next_udf;
        end
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: three counter configurations driven in lockstep and
// checked against a behavioural model through an expected-value queue.
module tb_param_updown_counter;
    logic clk_out = 1'b0;
    logic rst = 1'b0, clear = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0, flag_clr = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] d_out [3];
    logic [3:0] d_gray [3];
    logic d_tc [3];
    logic d_ovf [3];
    logic d_udf [3];
    int errors = 0;
    int checks = 0;
    int mx [3] = '{15, 9, 9};
    bit sat [3] = '{1'b0, 1'b0, 1'b1};
    int m_out [3];
    bit m_tc [3], m_ovf [3], m_udf [3];
    logic [32:0] exp_q [$];

    always #5 clk_out = ~clk_out;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0)) u0 (
        .clk_out(clk_out), .rst(rst), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .flag_clr(flag_clr), .out(d_out[0]), .gray_out(d_gray[0]),
        .tc(d_tc[0]), .ovf(d_ovf[0]), .udf(d_udf[0]));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u1 (
        .clk_out(clk_out), .rst(rst), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .flag_clr(flag_clr), .out(d_out[1]), .gray_out(d_gray[1]),
        .tc(d_tc[1]), .ovf(d_ovf[1]), .udf(d_udf[1]));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u2 (
        .clk_out(clk_out), .rst(rst), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .flag_clr(flag_clr), .out(d_out[2]), .gray_out(d_gray[2]),
        .tc(d_tc[2]), .ovf(d_ovf[2]), .udf(d_udf[2]));

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Reference behaviour for one configuration, plain integer arithmetic.
    task automatic model(input int i);
        m_tc[i] = 1'b0;
        if (!rst || clear) begin
            m_out[i] = 0;
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
            return;
        end
        if (flag_clr) begin
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end
        if (load) begin
            m_out[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
        end else if (en && up_dn) begin
            if (m_out[i] == mx[i]) begin
                m_out[i] = sat[i] ? mx[i] : 0;
                m_tc[i] = 1'b1;
                m_ovf[i] = 1'b1;
            end else m_out[i]++;
        end else if (en) begin
            if (m_out[i] == 0) begin
                m_out[i] = sat[i] ? 0 : mx[i];
                m_tc[i] = 1'b1;
                m_udf[i] = 1'b1;
            end else m_out[i]--;
        end
    endtask

    function automatic logic [10:0] pack(input int i);
        logic [3:0] o;
        o = 4'(m_out[i]);
        return {o, o ^ (o >> 1), m_tc[i], m_ovf[i], m_udf[i]};
    endfunction

    task automatic step(input logic r, input logic c, input logic ld, input int lv,
                        input logic e, input logic ud, input logic fc);
        logic [32:0] want;
        rst = r; clear = c; load = ld; load_val = 4'(lv); en = e; up_dn = ud; flag_clr = fc;
        for (int i = 0; i < 3; i++) model(i);
        exp_q.push_back({pack(2), pack(1), pack(0)});
        @(posedge clk_out);
        #1;
        want = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            logic [10:0] w;
            w = want[i*11 +: 11];
            check($sformatf("u%0d.out", i), int'(d_out[i]), int'(w[10:7]));
            check($sformatf("u%0d.gray", i), int'(d_gray[i]), int'(w[6:3]));
            check($sformatf("u%0d.tc", i), int'(d_tc[i]), int'(w[2]));
            check($sformatf("u%0d.ovf", i), int'(d_ovf[i]), int'(w[1]));
            check($sformatf("u%0d.udf", i), int'(d_udf[i]), int'(w[0]));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_out[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 1, 1, 0);
        check("reset.out15", int'(d_out[0]), 0);
        for (int k = 0; k < 17; k++) step(1, 0, 0, 0, 1, 1, 0);
        check("wrap15.out", int'(d_out[0]), 1);
        step(1, 0, 1, 12, 0, 0, 0);
        check("load_clamp", int'(d_out[1]), 9);
        for (int k = 0; k < 11; k++) step(1, 0, 0, 0, 1, 0, 0);
        check("down_wrap9", int'(d_out[1]), 8);
        step(1, 0, 1, 8, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 1, 0);
        check("sat_hold", int'(d_out[2]), 9);
        check("sat_tc", int'(d_tc[2]), 1);
        step(1, 0, 1, 5, 0, 0, 0);
        step(1, 1, 1, 3, 1, 1, 0);
        check("clear_prio", int'(d_out[0]), 0);
        step(1, 0, 1, 3, 1, 1, 0);
        check("load_prio", int'(d_out[0]), 3);
        step(1, 0, 1, 15, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check("flag_clr", int'(d_ovf[0]), 0);
        step(1, 0, 1, 15, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 1);
        check("set_wins", int'(d_ovf[0]), 1);
        step(1, 0, 1, 6, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        check("resume", int'(d_out[0]), 1);
        for (int k = 0; k < 200; k++)
            step(1, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
